store_aligner: RTL

Registered store path between the execute stage and the data-memory write port. Accepts one store request per handshake (byte/half/word/double), aligns the data into bus lanes, generates byte strobes and issues a bus write. It reports completion or an alignment/size fault. Parametrised in bus width. An optional mode splits boundary-crossing stores into two bus beats.

---
 rtl/store_aligner.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/store_aligner.sv
// store_aligner: registered store path from execute stage to the data-memory
// write port. Accepts one byte/half/word/double store per handshake, moves the
// data into its byte lanes, builds byte strobes and issues a bus write beat,
// then reports completion or a fault on a one-cycle response pulse.
//
// Build option STORE_ALIGNER_SPLIT_EN: when defined, misaligned stores are
// performed, and stores that cross a bus word are issued as two beats
// (BEAT1 state). When undefined, any store with addr mod size != 0 faults
// and every legal store is exactly one beat.
module store_aligner #(
  parameter int BUS_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_type,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [BUS_W-1:0]     req_data,
  output logic                 bus_valid,
  input  logic                 bus_ready,
  output logic [ADDR_W-1:0]    bus_addr,
  output logic [BUS_W-1:0]     bus_data,
  output logic [BUS_W/8-1:0]   bus_strb,
  output logic                 resp_valid,
  output logic                 resp_fault
);

  localparam int BUS_B = BUS_W / 8;
  localparam int OFF_W = $clog2(BUS_B);
`ifdef STORE_ALIGNER_SPLIT_EN
  localparam int SB_W  = 2 * BUS_B;   // strobes across two adjacent bus words
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1
`ifdef STORE_ALIGNER_SPLIT_EN
    ,
    S_BEAT1 = 2'd2
`endif
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  // Expand a byte-enable vector into a bit mask over the data bus.
  function automatic logic [BUS_W-1:0] lane_mask(input logic [BUS_B-1:0] strb);
    logic [BUS_W-1:0] m;
    m = '0;
    for (int i = 0; i < BUS_B; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                w_accept;
  logic                w_bus_hs;
  logic [OFF_W-1:0]    w_off;
  logic [ADDR_W-1:0]   w_base;
  logic [7:0]          w_ones;        // (1 << size) - 1, size = 1 << req_type
  logic                w_size_fault;
  logic                w_fault;
  logic [BUS_B-1:0]    w_strb_lo;
  logic [BUS_W-1:0]    w_data_lo;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_bus_hs  = bus_valid && bus_ready;
  assign w_off     = req_addr[OFF_W-1:0];
  assign w_base    = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // A double does not fit a 32-bit bus at all, regardless of alignment.
  assign w_size_fault = (BUS_W == 32) && (req_type == 2'd3);

  // Contiguous byte-enable run for the requested size, before shifting.
  always_comb begin
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    w_ones = 8'h01;
    case (req_type)
      2'd0:    w_ones = 8'h01;
      2'd1:    w_ones = 8'h03;
      2'd2:    w_ones = 8'h0F;
      default: w_ones = 8'hFF;
    endcase
  end

`ifdef STORE_ALIGNER_SPLIT_EN
  // Shift into a two-word window: the low word is beat 0, the high word is
  // whatever spilled over the bus-word boundary and becomes beat 1.
  logic [SB_W-1:0]     w_strb_wide;
  logic [2*BUS_W-1:0]  w_data_wide;
  logic [BUS_B-1:0]    w_strb_hi;
  logic [BUS_W-1:0]    w_data_hi;

  assign w_strb_wide = SB_W'(w_ones) << w_off;
  assign w_data_wide = {{BUS_W{1'b0}}, req_data} << {w_off, 3'b000};
  assign w_strb_lo   = w_strb_wide[BUS_B-1:0];
  assign w_strb_hi   = w_strb_wide[SB_W-1:BUS_B];
  assign w_data_lo   = w_data_wide[BUS_W-1:0]       & lane_mask(w_strb_lo);
  assign w_data_hi   = w_data_wide[2*BUS_W-1:BUS_W] & lane_mask(w_strb_hi);
  assign w_fault     = w_size_fault;
`else
  // Aligned stores never leave the bus word, so a single-word shift suffices.
  logic [2:0] w_low_mask;
  logic       w_misalign;

  // Address bits that must be zero for a naturally aligned store.
  always_comb begin
    w_low_mask = 3'b000;
    case (req_type)
      2'd0:    w_low_mask = 3'b000;
      2'd1:    w_low_mask = 3'b001;
      2'd2:    w_low_mask = 3'b011;
      default: w_low_mask = 3'b111;
    endcase
  end

  assign w_misalign = |(req_addr[2:0] & w_low_mask);
  assign w_strb_lo  = BUS_B'(w_ones) << w_off;
  assign w_data_lo  = (req_data << {w_off, 3'b000}) & lane_mask(w_strb_lo);
  assign w_fault    = w_size_fault || w_misalign;
`endif

  // ---------------------------------------------------------------------------
  // Beat-1 holding registers (split build only)
  // ---------------------------------------------------------------------------
`ifdef STORE_ALIGNER_SPLIT_EN
  logic [BUS_B-1:0] r_hi_strb;
  logic [BUS_W-1:0] r_hi_data;
  logic             w_cross;

  assign w_cross = |r_hi_strb;

  // Capture the spill-over half of the store at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_strb <= '0;
      r_hi_data <= '0;
    end else if (w_accept && !w_fault) begin
      r_hi_strb <= w_strb_hi;
      r_hi_data <= w_data_hi;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its inputs from before the edge, independent of block order.
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: faults never leave IDLE; each beat waits for bus_ready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_fault) w_state_nxt = S_BEAT0;
      end
      S_BEAT0: begin
        if (bus_ready) begin
`ifdef STORE_ALIGNER_SPLIT_EN
          w_state_nxt = w_cross ? S_BEAT1 : S_IDLE;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef STORE_ALIGNER_SPLIT_EN
      S_BEAT1: begin
        if (bus_ready) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered bus and response outputs
  // ---------------------------------------------------------------------------
  logic                r_bus_valid;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [BUS_W-1:0]    r_bus_data;
  logic [BUS_B-1:0]    r_bus_strb;
  logic                r_resp_valid;
  logic                r_resp_fault;

  // Load beat 0 on accept, swap in beat 1 or retire on each handshake; the
  // beat is untouched while the memory stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_valid  <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_data   <= '0;
      r_bus_strb   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      if (w_accept) begin
        if (w_fault) begin
          r_resp_valid <= 1'b1;
          r_resp_fault <= 1'b1;
        end else begin
          r_bus_valid <= 1'b1;
          r_bus_addr  <= w_base;
          r_bus_data  <= w_data_lo;
          r_bus_strb  <= w_strb_lo;
        end
      end else if (w_bus_hs) begin
`ifdef STORE_ALIGNER_SPLIT_EN
        if (r_state == S_BEAT0 && w_cross) begin
          // Address wraps modulo 2^ADDR_W by plain truncating addition.
          r_bus_addr <= r_bus_addr + ADDR_W'(BUS_B);
          r_bus_data <= r_hi_data;
          r_bus_strb <= r_hi_strb;
        end else begin
          r_bus_valid  <= 1'b0;
          r_resp_valid <= 1'b1;
        end
`else
        r_bus_valid  <= 1'b0;
        r_resp_valid <= 1'b1;
`endif
      end
    end
  end

  assign bus_valid  = r_bus_valid;
  assign bus_addr   = r_bus_addr;
  assign bus_data   = r_bus_data;
  assign bus_strb   = r_bus_strb;
  assign resp_valid = r_resp_valid;
  assign resp_fault = r_resp_fault;

endmodule
